// File: rtl/ulpi_pkg.sv
// ulpi_pkg: ULPI register addresses and the PHY init write table
package ulpi_pkg;
  localparam logic [5:0] FUNC_CTRL = 6'h04;
  localparam logic [5:0] IFC_CTRL = 6'h07;
  localparam logic [5:0] OTG_CTRL = 6'h0A;
  localparam int N_WRITES = 3;
  localparam int IDX_W = $clog2(N_WRITES + 1);
  typedef logic [IDX_W-1:0] idx_t;
  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } ulpi_wr_t;
  // FUNC_CTRL 0x49: non-driving, full speed, SuspendM=1
  localparam ulpi_wr_t [0:N_WRITES-1] INIT_TABLE = '{
    '{FUNC_CTRL, 8'h49},
    '{OTG_CTRL, 8'h00},
    '{IFC_CTRL, 8'h00}
  };
endpackage

// File: rtl/ulpi_init_rom.sv
// ulpi_init_rom: combinational lookup of the init table entry for an index
module ulpi_init_rom
  import ulpi_pkg::*;
(
  input  idx_t     idx,
  output ulpi_wr_t entry
);
  assign entry = (idx < idx_t'(N_WRITES)) ? INIT_TABLE[idx] : '0;
endmodule

// File: rtl/ulpi_init_seq.sv
// ulpi_init_seq: issues the ULPI PHY init register writes after a start-up delay
module ulpi_init_seq
  import ulpi_pkg::*;
#(
  parameter int STARTUP_DELAY = 1024,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       START,
  input  logic       DIR,
  input  logic       WR_BUSY,
  output logic       WRITE_DATA,
  output logic [7:0] DATA,
  output logic [5:0] ADDR,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DELAY = 3'd1;
  localparam logic [2:0] S_WAIT_BUS = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;
  localparam logic [2:0] S_FAIL = 3'd7;
  localparam int MAXC = STARTUP_DELAY > TIMEOUT_CYCLES ? STARTUP_DELAY : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 2);
  // counters count down to zero, so loading N-1 gives N cycles in the state
  localparam logic [CW-1:0] D_LOAD = CW'(STARTUP_DELAY - 1);
  localparam logic [CW-1:0] T_LOAD = CW'(TIMEOUT_CYCLES - 1);
  logic [2:0] state;
  logic [CW-1:0] cnt;
  idx_t idx;
  idx_t idx_nxt;
  logic last;
  ulpi_wr_t entry;
  ulpi_init_rom u_rom (
    .idx  (idx),
    .entry(entry)
  );
  assign idx_nxt = idx + idx_t'(1);
  assign last = idx_nxt == idx_t'(N_WRITES);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
      WRITE_DATA <= 1'b0;
      DATA <= '0;
      ADDR <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ERROR <= 1'b0;
    end else begin
      WRITE_DATA <= 1'b0;
      case (state)
        S_IDLE, S_FINISH, S_FAIL:
          if (START) begin
            state <= (STARTUP_DELAY == 0) ? S_WAIT_BUS : S_DELAY;
            cnt <= D_LOAD;
            idx <= '0;
            BUSY <= 1'b1;
            DONE <= 1'b0;
            ERROR <= 1'b0;
          end
        S_DELAY:
          if (cnt == '0) state <= S_WAIT_BUS;
          else cnt <= cnt - CW'(1);
        S_WAIT_BUS:
          if (!DIR) begin
            state <= S_ISSUE;
            WRITE_DATA <= 1'b1;
            ADDR <= entry.addr;
            DATA <= entry.data;
          end
        S_ISSUE: begin
          state <= S_WAIT_ACK;
          cnt <= T_LOAD;
        end
        S_WAIT_ACK:
          if (WR_BUSY) begin
            state <= S_WAIT_DONE;
            cnt <= T_LOAD;
          end else if (cnt == '0) begin
            state <= S_FAIL;
            BUSY <= 1'b0;
            ERROR <= 1'b1;
          end else cnt <= cnt - CW'(1);
        S_WAIT_DONE:
          if (!WR_BUSY) begin
            idx <= idx_nxt;
            state <= last ? S_FINISH : S_WAIT_BUS;
            BUSY <= !last;
            DONE <= last;
          end else if (cnt == '0) begin
            state <= S_FAIL;
            BUSY <= 1'b0;
            ERROR <= 1'b1;
          end else cnt <= cnt - CW'(1);
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ulpi_init_seq.sv
// tb_ulpi_init_seq: directed checks of the ULPI init sequencer
module tb_ulpi_init_seq;
  localparam int SD = 4;
  localparam int TO = 10;
  logic clk = 1'b0;
  logic rst, START, DIR, WR_BUSY;
  logic WRITE_DATA, BUSY, DONE, ERROR;
  logic [7:0] DATA;
  logic [5:0] ADDR;
  int checks = 0, passes = 0, fails = 0;
  logic model_en = 1'b0, stuck = 1'b0;
  logic [5:0] got_a [3];
  logic [7:0] got_d [3];
  int n, lat, bad, hits;
  bit ok, done1;

  always #5 clk = ~clk;

  ulpi_init_seq #(.STARTUP_DELAY(SD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .START(START), .DIR(DIR), .WR_BUSY(WR_BUSY),
    .WRITE_DATA(WRITE_DATA), .DATA(DATA), .ADDR(ADDR),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  // register-write block model: BUSY rises one cycle after a request, stays up 3 cycles
  initial begin
    WR_BUSY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      WR_BUSY = stuck;
      if (model_en && WRITE_DATA) begin
        @(posedge clk);
        #1 WR_BUSY = 1'b1;
        repeat (3) @(posedge clk);
        #1 WR_BUSY = 1'b0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit spam);
    logic prev = 1'b0;
    n = 0; lat = -1; bad = 0; done1 = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step;
      if (c == 1) done1 = DONE;
      if (WRITE_DATA) begin
        if (n < 3) begin
          got_a[n] = ADDR;
          got_d[n] = DATA;
        end
        if (n == 0) lat = c;
        if (prev) bad++;
        n++;
      end else if (n > 0 && n <= 3 && BUSY && (ADDR !== got_a[n-1] || DATA !== got_d[n-1])) bad++;
      prev = WRITE_DATA;
      if (DONE || ERROR) begin
        START = 1'b0;
        break;
      end
      START = spam && (c % 3 == 0);
    end
  endtask

  task automatic wait_wd(input int lim);
    ok = 1'b0;
    for (int c = 0; c < lim; c++) begin
      step;
      START = 1'b0;
      if (WRITE_DATA) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_table(input string tag);
    chk({tag, "_n"}, n, 3);
    chk({tag, "_bad"}, bad, 0);
    chk({tag, "_a0"}, 32'(got_a[0]), 32'h04);
    chk({tag, "_d0"}, 32'(got_d[0]), 32'h49);
    chk({tag, "_a1"}, 32'(got_a[1]), 32'h0A);
    chk({tag, "_d1"}, 32'(got_d[1]), 32'h00);
    chk({tag, "_a2"}, 32'(got_a[2]), 32'h07);
    chk({tag, "_d2"}, 32'(got_d[2]), 32'h00);
    chk({tag, "_done"}, 32'(DONE), 1);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    chk({tag, "_err"}, 32'(ERROR), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; START = 1'b0; DIR = 1'b0;
    repeat (3) step;
    chk("rst_outs", 32'({WRITE_DATA, BUSY, DONE, ERROR, ADDR, DATA}), 0);
    rst = 1'b0;
    repeat (3) step;
    chk("idle_busy", 32'(BUSY), 0);
    // basic run
    model_en = 1'b1;
    START = 1'b1;
    run(1'b0);
    chk("run1_lat", lat, SD + 2);
    chk_table("run1");
    repeat (5) step;
    chk("done_hold", 32'(DONE), 1);
    // START spam mid-run, started from FINISH
    START = 1'b1;
    run(1'b1);
    chk("rerun_clr", 32'(done1), 0);
    chk("rerun_lat", lat, SD + 2);
    chk_table("spam");
    // DIR held high in WAIT_BUS
    DIR = 1'b1;
    START = 1'b1;
    step;
    START = 1'b0;
    hits = 0;
    repeat (SD + 20) begin
      step;
      if (WRITE_DATA) hits++;
    end
    chk("dir_nowr", hits, 0);
    chk("dir_busy", 32'(BUSY), 1);
    DIR = 1'b0;
    step;
    chk("dir_wr", 32'(WRITE_DATA), 1);
    chk("dir_addr", 32'(ADDR), 32'h04);
    for (int c = 0; c < 200 && !DONE; c++) step;
    chk("dir_done", 32'(DONE), 1);
    // WR_BUSY never rises
    model_en = 1'b0;
    START = 1'b1;
    wait_wd(50);
    chk("to_wr", 32'(ok), 1);
    repeat (TO) step;
    chk("to_early", 32'(ERROR), 0);
    chk("to_busy", 32'(BUSY), 1);
    step;
    chk("to_err", 32'(ERROR), 1);
    chk("to_done", 32'(DONE), 0);
    chk("to_idle", 32'(BUSY), 0);
    repeat (5) step;
    chk("to_hold", 32'(ERROR), 1);
    // WR_BUSY stuck high: timeout in WAIT_DONE
    START = 1'b1;
    wait_wd(50);
    chk("stk_clr", 32'(ERROR), 0);
    stuck = 1'b1;
    for (int c = 0; c < 3 * TO && !ERROR; c++) step;
    chk("stk_err", 32'(ERROR), 1);
    stuck = 1'b0;
    step;
    // reset during 2nd write's WAIT_DONE
    model_en = 1'b1;
    START = 1'b1;
    wait_wd(50);
    wait_wd(50);
    chk("rs_wr2", 32'(ADDR), 32'h0A);
    repeat (3) step;
    rst = 1'b1;
    step;
    chk("rs_outs", 32'({WRITE_DATA, BUSY, DONE, ERROR, ADDR, DATA}), 0);
    rst = 1'b0;
    hits = 0;
    repeat (20) begin
      step;
      if (WRITE_DATA || BUSY) hits++;
    end
    chk("rs_quiet", hits, 0);
    START = 1'b1;
    wait_wd(50);
    chk("rs_restart", 32'(ok), 1);
    chk("rs_addr", 32'(ADDR), 32'h04);
    chk("rs_data", 32'(DATA), 32'h49);
    for (int c = 0; c < 200 && !DONE; c++) step;
    chk("rs_done", 32'(DONE), 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
